// File: rtl/imager_frame_sequencer.sv
// Frame-level sequencer: gates the exposure FSM, answers its FSMIND1/FSMIND0
// handshakes, reads out C_NUM_ROWS rows per frame, counts frames, flags timeouts.
module imager_frame_sequencer #(
    parameter int unsigned C_NUM_ROWS = 160,
    parameter int unsigned C_TIMEOUT  = 2000000,
    parameter int unsigned C_MIN_PATT = 2
) (
    input  logic        CLKMPRE,
    input  logic        RESET,
    input  logic        START,
    input  logic        STOP,
    input  logic [31:0] HOST_EXP_SUBC,
    input  logic [31:0] HOST_NUM_PAT,
    input  logic [31:0] HOST_NUM_FRAMES,
    output logic        EXP_RESET,
    output logic [31:0] EXP_SUBC,
    output logic [31:0] NUM_PAT,
    input  logic        FSMIND1,
    output logic        FSMIND1ACK,
    output logic        FSMIND0,
    input  logic        FSMIND0ACK,
    output logic        RO_START,
    output logic [7:0]  RO_ROW,
    input  logic        RO_DONE,
    output logic        BUSY,
    output logic        ERROR,
    output logic [31:0] FRAME_CNT,
    output logic [7:0]  seq_stat
);

    // One-hot encoding doubles as the seq_stat debug code.
    typedef enum logic [7:0] {
        S_IDLE    = 8'h01,
        S_LOAD    = 8'h02,
        S_EXPOSE  = 8'h04,
        S_ACK1    = 8'h08,
        S_RD_REQ  = 8'h10,
        S_RD_WAIT = 8'h20,
        S_REARM   = 8'h40,
        S_ERR     = 8'h80
    } state_t;

    localparam logic [7:0]  LAST_ROW     = 8'(C_NUM_ROWS - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(C_TIMEOUT - 1);
    localparam logic [31:0] MIN_PATT     = 32'(C_MIN_PATT);

    state_t      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  ro_row_q, ro_row_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] exp_subc_q, exp_subc_d;
    logic [31:0] num_pat_q, num_pat_d;
    logic [31:0] num_frames_q, num_frames_d;
    logic        stop_q, stop_d;
    logic        error_q, error_d;
    logic        busy;
    logic        timed_out;
    logic        last_frame;

    assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
    assign timed_out  = (wait_cnt_q == TIMEOUT_LAST);
    assign last_frame = stop_q || ((num_frames_q != 32'd0) && (frame_cnt_q == num_frames_q));

    // Handshakes are level based: FSMIND1ACK is raised on FSMIND1 and held until
    // the rearm exchange completes; FSMIND0 is held until FSMIND0ACK=1 is seen
    // together with FSMIND1=0, and both acks then drop in the same cycle.
    always_comb begin
        state_d      = state_q;
        ro_row_d     = ro_row_q;
        frame_cnt_d  = frame_cnt_q;
        exp_subc_d   = exp_subc_q;
        num_pat_d    = num_pat_q;
        num_frames_d = num_frames_q;
        stop_d       = stop_q;
        error_d      = error_q;

        if (STOP && busy) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d     = S_LOAD;
                    error_d     = 1'b0;
                    frame_cnt_d = 32'd0;
                    stop_d      = 1'b0;
                end
            end
            S_LOAD: begin
                exp_subc_d   = HOST_EXP_SUBC;
                num_pat_d    = (HOST_NUM_PAT < MIN_PATT) ? MIN_PATT : HOST_NUM_PAT;
                num_frames_d = HOST_NUM_FRAMES;
                state_d      = S_EXPOSE;
            end
            S_EXPOSE: begin
                if (FSMIND1) begin
                    state_d = S_ACK1;
                end else if (timed_out) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_ACK1: begin
                ro_row_d = 8'd0;
                state_d  = S_RD_REQ;
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (RO_DONE) begin
                    if (ro_row_q < LAST_ROW) begin
                        ro_row_d = ro_row_q + 8'd1;
                        state_d  = S_RD_REQ;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        state_d     = S_REARM;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_REARM: begin
                if (FSMIND0ACK && !FSMIND1) begin
                    if (last_frame) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_ERR: begin
                if (START) begin
                    state_d     = S_LOAD;
                    error_d     = 1'b0;
                    frame_cnt_d = 32'd0;
                    stop_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter restarts on every state change and only runs in wait states.
    always_comb begin
        wait_cnt_d = 32'd0;
        if ((state_d == state_q) &&
            ((state_q == S_EXPOSE) || (state_q == S_RD_WAIT) || (state_q == S_REARM))) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLKMPRE) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 32'd0;
            ro_row_q     <= 8'd0;
            frame_cnt_q  <= 32'd0;
            exp_subc_q   <= 32'd0;
            num_pat_q    <= MIN_PATT;
            num_frames_q <= 32'd0;
            stop_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ro_row_q     <= ro_row_d;
            frame_cnt_q  <= frame_cnt_d;
            exp_subc_q   <= exp_subc_d;
            num_pat_q    <= num_pat_d;
            num_frames_q <= num_frames_d;
            stop_q       <= stop_d;
            error_q      <= error_d;
        end
    end

    assign EXP_RESET  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_ERR);
    assign FSMIND1ACK = (state_q == S_ACK1) || (state_q == S_RD_REQ) ||
                        (state_q == S_RD_WAIT) || (state_q == S_REARM);
    assign FSMIND0    = (state_q == S_REARM);
    assign RO_START   = (state_q == S_RD_REQ);
    assign RO_ROW     = ro_row_q;
    assign BUSY       = busy;
    assign ERROR      = error_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign EXP_SUBC   = exp_subc_q;
    assign NUM_PAT    = num_pat_q;
    assign seq_stat   = state_q;

endmodule

// File: tb/tb_imager_frame_sequencer.sv
// Directed bench for imager_frame_sequencer with an exposure-FSM driver and a
// 3-cycle ADC model that checks every requested row against an expected queue.
module tb_imager_frame_sequencer;

  localparam logic [7:0] ST_IDLE   = 8'h01;
  localparam logic [7:0] ST_LOAD   = 8'h02;
  localparam logic [7:0] ST_EXPOSE = 8'h04;
  localparam logic [7:0] ST_ACK1   = 8'h08;
  localparam logic [7:0] ST_REARM  = 8'h40;
  localparam logic [7:0] ST_ERR    = 8'h80;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] host_exp_subc;
  logic [31:0] host_num_pat;
  logic [31:0] host_num_frames;
  logic        exp_reset;
  logic [31:0] exp_subc;
  logic [31:0] num_pat;
  logic        fsmind1;
  logic        fsmind1ack;
  logic        fsmind0;
  logic        fsmind0ack;
  logic        ro_start;
  logic [7:0]  ro_row;
  logic        ro_done;
  logic        busy;
  logic        error;
  logic [31:0] frame_cnt;
  logic [7:0]  seq_stat;

  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         starts_seen = 0;
  int         adc_dly = 0;

  imager_frame_sequencer #(
    .C_NUM_ROWS(160),
    .C_TIMEOUT (100),
    .C_MIN_PATT(2)
  ) dut (
    .CLKMPRE        (clk),
    .RESET          (reset),
    .START          (start),
    .STOP           (stop),
    .HOST_EXP_SUBC  (host_exp_subc),
    .HOST_NUM_PAT   (host_num_pat),
    .HOST_NUM_FRAMES(host_num_frames),
    .EXP_RESET      (exp_reset),
    .EXP_SUBC       (exp_subc),
    .NUM_PAT        (num_pat),
    .FSMIND1        (fsmind1),
    .FSMIND1ACK     (fsmind1ack),
    .FSMIND0        (fsmind0),
    .FSMIND0ACK     (fsmind0ack),
    .RO_START       (ro_start),
    .RO_ROW         (ro_row),
    .RO_DONE        (ro_done),
    .BUSY           (busy),
    .ERROR          (error),
    .FRAME_CNT      (frame_cnt),
    .seq_stat       (seq_stat)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before 900000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ADC model: RO_DONE three cycles after each RO_START
  initial begin
    ro_done = 1'b0;
    forever begin
      @(negedge clk);
      ro_done = 1'b0;
      if (adc_dly > 0) begin
        adc_dly--;
        if (adc_dly == 0) ro_done = 1'b1;
      end
      if (ro_start) begin
        starts_seen++;
        if (exp_q.size() == 0) check("ro_extra", 32'd1, 32'd0);
        else check("ro_row", {24'd0, ro_row}, {24'd0, exp_q.pop_front()});
        adc_dly = 3;
      end
    end
  end

  task automatic wait_state(input logic [7:0] st, input int max_cyc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      if (seq_stat == st) found = 1'b1;
      else @(negedge clk);
    end
    check(tag, {24'd0, seq_stat}, {24'd0, st});
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_row(input logic [7:0] row, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (ro_start && ro_row == row) found = 1'b1;
      else @(negedge clk);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  // action: 0 none, 1 change HOST_EXP_SUBC, 2 STOP, 3 START while busy
  task automatic run_frame(input logic [31:0] subc, input logic [31:0] pat, input int action,
                           input logic [31:0] fcnt, input logic [7:0] nxt);
    int start0;
    wait_state(ST_EXPOSE, 20, "expose");
    check("exp_subc", exp_subc, subc);
    check("num_pat", num_pat, pat);
    check("exp_reset_lo", {31'd0, exp_reset}, 32'd0);
    @(negedge clk);
    for (int r = 0; r < 160; r++) exp_q.push_back(8'(r));
    start0  = starts_seen;
    fsmind1 = 1'b1;
    @(negedge clk);
    check("ack1_state", {24'd0, seq_stat}, {24'd0, ST_ACK1});
    check("ind1ack_hi", {31'd0, fsmind1ack}, 32'd1);
    if (action != 0) begin
      wait_row(8'd80, "mid_trig");
      case (action)
        1: host_exp_subc = 32'd40;
        2: stop = 1'b1;
        default: start = 1'b1;
      endcase
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      check("subc_hold", exp_subc, subc);
    end
    wait_state(ST_REARM, 3000, "rearm");
    check("rearm_ind0", {31'd0, fsmind0}, 32'd1);
    check("rearm_ind1ack", {31'd0, fsmind1ack}, 32'd1);
    check("row_pulses", 32'(starts_seen - start0), 32'd160);
    check("rows_left", 32'(exp_q.size()), 32'd0);
    check("frame_cnt", frame_cnt, fcnt);
    fsmind0ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rearm_hold", {24'd0, seq_stat}, {24'd0, ST_REARM});
    end
    fsmind1 = 1'b0;
    @(negedge clk);
    check("rearm_exit", {24'd0, seq_stat}, {24'd0, nxt});
    check("ind0_lo", {31'd0, fsmind0}, 32'd0);
    check("ind1ack_lo", {31'd0, fsmind1ack}, 32'd0);
    fsmind0ack = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_exp_reset"}, {31'd0, exp_reset}, 32'd1);
    check({pfx, "_ind1ack"}, {31'd0, fsmind1ack}, 32'd0);
    check({pfx, "_ind0"}, {31'd0, fsmind0}, 32'd0);
    check({pfx, "_ro_start"}, {31'd0, ro_start}, 32'd0);
    check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check({pfx, "_error"}, {31'd0, error}, 32'd0);
    check({pfx, "_frame_cnt"}, frame_cnt, 32'd0);
    check({pfx, "_ro_row"}, {24'd0, ro_row}, 32'd0);
    check({pfx, "_exp_subc"}, exp_subc, 32'd0);
    check({pfx, "_num_pat"}, num_pat, 32'd2);
    check({pfx, "_state"}, {24'd0, seq_stat}, {24'd0, ST_IDLE});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    host_exp_subc = 32'd0;
    host_num_pat = 32'd0;
    host_num_frames = 32'd0;
    fsmind1 = 1'b0;
    fsmind0ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);

    // single frame
    host_num_frames = 32'd1;
    host_num_pat = 32'd5;
    host_exp_subc = 32'd10;
    pulse_start(1'b0);
    check("load_state", {24'd0, seq_stat}, {24'd0, ST_LOAD});
    check("load_exp_reset", {31'd0, exp_reset}, 32'd1);
    check("load_busy", {31'd0, busy}, 32'd1);
    run_frame(32'd10, 32'd5, 0, 32'd1, ST_IDLE);
    check("t1_frame_cnt", frame_cnt, 32'd1);
    check("t1_exp_reset", {31'd0, exp_reset}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // clamp and reload
    host_num_pat = 32'd0;
    host_num_frames = 32'd3;
    host_exp_subc = 32'd10;
    pulse_start(1'b0);
    run_frame(32'd10, 32'd2, 1, 32'd1, ST_LOAD);
    run_frame(32'd40, 32'd2, 0, 32'd2, ST_LOAD);
    run_frame(32'd40, 32'd2, 0, 32'd3, ST_IDLE);
    check("t2_frame_cnt", frame_cnt, 32'd3);

    // continuous + STOP; STOP in idle and START+STOP together are not recorded
    host_num_frames = 32'd0;
    host_num_pat = 32'd7;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("idle_stop_ign", {24'd0, seq_stat}, {24'd0, ST_IDLE});
    pulse_start(1'b1);
    run_frame(32'd40, 32'd7, 0, 32'd1, ST_LOAD);
    run_frame(32'd40, 32'd7, 3, 32'd2, ST_LOAD);
    run_frame(32'd40, 32'd7, 0, 32'd3, ST_LOAD);
    run_frame(32'd40, 32'd7, 2, 32'd4, ST_IDLE);
    check("t3_frame_cnt", frame_cnt, 32'd4);

    // timeout in S_EXPOSE after one good frame
    host_exp_subc = 32'd7;
    host_num_pat = 32'd9;
    pulse_start(1'b0);
    run_frame(32'd7, 32'd9, 0, 32'd1, ST_LOAD);
    wait_state(ST_EXPOSE, 20, "to_expose");
    repeat (99) @(negedge clk);
    check("to_not_yet", {24'd0, seq_stat}, {24'd0, ST_EXPOSE});
    @(negedge clk);
    check("to_err_state", {24'd0, seq_stat}, {24'd0, ST_ERR});
    check("to_error", {31'd0, error}, 32'd1);
    check("to_exp_reset", {31'd0, exp_reset}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_ind1ack", {31'd0, fsmind1ack}, 32'd0);
    check("to_frame_cnt", frame_cnt, 32'd1);
    repeat (5) @(negedge clk);
    check("to_sticky", {31'd0, error}, 32'd1);
    pulse_start(1'b0);
    check("err_restart", {24'd0, seq_stat}, {24'd0, ST_LOAD});
    check("err_cleared", {31'd0, error}, 32'd0);
    check("err_frame_cnt", frame_cnt, 32'd0);

    // reset mid-readout at row 37
    wait_state(ST_EXPOSE, 20, "rr_expose");
    for (int r = 0; r < 160; r++) exp_q.push_back(8'(r));
    fsmind1 = 1'b1;
    wait_row(8'd37, "rr_trig");
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rr");
    exp_q.delete();
    fsmind1 = 1'b0;
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("rr_no_start", {31'd0, ro_start}, 32'd0);
    end
    check("rr_idle", {24'd0, seq_stat}, {24'd0, ST_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
